// File: rtl/viterbi_pkg.sv
// Shared constants and types for the convolutional encoder on the Viterbi link.
package viterbi_pkg;

  localparam int K             = 4;
  localparam int SR_W          = K - 1;
  localparam int TCNT_W        = $clog2(K);
  localparam int FRAME_LEN_DEF = 1024;

  // Bit K-1 of each generator taps the incoming bit.
  localparam logic [K-1:0] G0_DEF = 4'b1101;
  localparam logic [K-1:0] G1_DEF = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    TAIL,
    DONE
  } enc_state_t;

  function automatic logic parity(input logic [K-1:0] full, input logic [K-1:0] gen);
    return ^(full & gen);
  endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Encoder shift register and generator parity trees; the symbol is combinational
// from the current bit and state, the register advances only on adv.
module conv_enc_core
  import viterbi_pkg::*;
#(
  parameter logic [K-1:0] G0 = G0_DEF,
  parameter logic [K-1:0] G1 = G1_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       adv,
  input  logic       clr,
  input  logic       b,
  output logic [1:0] sym
);

  logic [SR_W-1:0] sr;
  logic [K-1:0]    full;

  assign full = {b, sr};
  assign sym  = {parity(full, G0), parity(full, G1)};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr <= '0;
    end else if (clr) begin
      sr <= '0;
    end else if (adv) begin
      sr <= {b, sr[SR_W-1:1]};
    end
  end

endmodule

// File: rtl/conv_encoder_framer.sv
// Frames a serial bit stream into rate-1/2 coded symbols, zero-terminating each
// frame with K-1 tail bits so the decoder trellis ends in state 0.
//
// state | meaning
// IDLE  | waiting for start
// DATA  | accepting info bits, one symbol per accepted bit
// TAIL  | shifting in K-1 zeros, one symbol per cycle
// DONE  | clears the shift register, frame_done follows next cycle
module conv_encoder_framer
  import viterbi_pkg::*;
#(
  parameter int           FRAME_LEN = FRAME_LEN_DEF,
  parameter logic [K-1:0] G0        = G0_DEF,
  parameter logic [K-1:0] G1        = G1_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  input  logic       in_bit,
  output logic       in_ready,
  output logic       out_valid,
  output logic [1:0] d_out,
  output logic       enc_enable,
  output logic       busy,
  output logic       frame_done
);

  localparam int                CNT_W     = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(FRAME_LEN - 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(K - 2);

  enc_state_t        state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [TCNT_W-1:0] tcnt, tcnt_nxt;
  logic              adv, clr, b;
  logic [1:0]        sym;

  conv_enc_core #(
    .G0(G0),
    .G1(G1)
  ) u_core (
    .clk(clk),
    .rst(rst),
    .adv(adv),
    .clr(clr),
    .b  (b),
    .sym(sym)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    tcnt_nxt  = tcnt;
    adv       = 1'b0;
    clr       = 1'b0;
    b         = 1'b0;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          clr       = 1'b1;
          cnt_nxt   = '0;
          state_nxt = DATA;
        end
      end
      DATA: begin
        in_ready = 1'b1;
        if (in_valid) begin
          adv     = 1'b1;
          b       = in_bit;
          cnt_nxt = cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            tcnt_nxt  = '0;
            state_nxt = TAIL;
          end
        end
      end
      TAIL: begin
        adv      = 1'b1;
        tcnt_nxt = tcnt + 1'b1;
        if (tcnt == TCNT_LAST) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        clr       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // enc_enable latches on the first symbol and only drops after the last tail symbol.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      tcnt       <= '0;
      out_valid  <= 1'b0;
      d_out      <= 2'b00;
      enc_enable <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      tcnt       <= tcnt_nxt;
      out_valid  <= adv;
      frame_done <= (state == DONE);
      if (adv) begin
        d_out      <= sym;
        enc_enable <= 1'b1;
      end else if (state == DONE) begin
        enc_enable <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
